// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared definitions for the memory access block: access-size encodings
// (shared with the load-size stage), the controller state enumeration and a
// helper that flags unsupported or misaligned requests.
package mem_access_pkg;

  localparam logic [1:0] OP_BYTE = 2'b00;
  localparam logic [1:0] OP_HALF = 2'b01;
  localparam logic [1:0] OP_WORD = 2'b10;
  localparam logic [1:0] OP_INV  = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    LATCH = 3'd2,
    WR    = 3'd3,
    DONE  = 3'd4
  } state_t;

  // True for an invalid size, or an access not aligned to its own size.
  function automatic logic req_bad(input logic [1:0] op, input logic [1:0] lsb);
    req_bad = (op == OP_INV) ||
              ((op == OP_WORD) && (lsb != 2'b00)) ||
              ((op == OP_HALF) && lsb[0]);
  endfunction

endpackage

// File: rtl/mem_access_st_merge.sv
// st_merge
// Combinational store merge: replaces the low byte / low halfword of the word
// read back from memory with store data; a word store passes store data whole.
// Ports:
//   op     - access size (OP_BYTE / OP_HALF / OP_WORD)
//   mdr    - memory data register (word previously read)
//   wdata  - captured store data
//   merged - word to write back
module st_merge
  import mem_access_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] mdr,
  input  logic [31:0] wdata,
  output logic [31:0] merged
);

  always_comb begin
    merged = wdata;
    case (op)
      OP_BYTE: merged = {mdr[31:8], wdata[7:0]};
      OP_HALF: merged = {mdr[31:16], wdata[15:0]};
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access
// Memory access controller for loads and stores. Loads read a word into the
// memory data register; word stores write directly; byte/halfword stores do a
// read-modify-write through st_merge. Bad requests finish at once with err.
//
// Handshake: start is a request strobe accepted only when busy=0 (IDLE); all
// request fields (we/op/addr/wdata) are captured on the accepting edge, so
// they need only be valid while start is high. done pulses for exactly one
// cycle when the access completes; busy is high from accept through done.
//
// Ports:
//   clk, reset_n           - clock, asynchronous active-low reset
//   start, we, op, addr    - request strobe, store/load, size, byte address
//   wdata                  - store data
//   mem_rdata              - memory read word
//   mem_addr, mem_wr       - word address, write enable (one cycle per store)
//   mem_wdata              - merged write word (zero outside WR)
//   mdr_out                - memory data register
//   busy, done, err        - status
//   state                  - current controller state (observability)
module mem_access
  import mem_access_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        we,
  input  logic [1:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mdr_out,
  output logic        busy,
  output logic        done,
  output logic        err,
  output state_t      state
);

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

  // Only the word address is kept; the byte offset matters only for the
  // alignment check made at accept time.
  logic [31:2] addr_q;
  logic [1:0]  op_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [2:0]  cnt;
  logic [31:0] merged;

  st_merge u_merge (
    .op     (op_q),
    .mdr    (mdr_out),
    .wdata  (wdata_q),
    .merged (merged)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      op_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      cnt     <= '0;
      mdr_out <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_q  <= addr[31:2];
            op_q    <= op;
            we_q    <= we;
            wdata_q <= wdata;
            err     <= req_bad(op, addr[1:0]);
            if (req_bad(op, addr[1:0])) begin
              state <= DONE;
            end else if (we && (op == OP_WORD)) begin
              state <= WR;
            end else begin
              // Loads and sub-word stores both need the current word first.
              state <= RD;
              cnt   <= CNT_INIT;
            end
          end
        end
        RD: begin
          if (cnt == 3'd0) state <= LATCH;
          else             cnt   <= cnt - 3'd1;
        end
        LATCH: begin
          mdr_out <= mem_rdata;
          state   <= we_q ? WR : DONE;
        end
        WR:      state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_addr  = {addr_q, 2'b00};
  assign mem_wr    = (state == WR);
  assign mem_wdata = mem_wr ? merged : 32'h0;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter MEM_LAT, default 1, memory read latency in cycles (range 1-7).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request strobe, sampled only in IDLE.
REQ-005 we  input  1  1 = store, 0 = load.
REQ-006 op  input  2  size: 00 byte, 01 halfword, 10 word, 11 invalid; same encoding as the load-size stage command.
REQ-007 addr  input  32  byte address of access.
REQ-008 wdata  input  32  store data from register file.
REQ-009 mem_rdata  input  32  memory read word.
REQ-010 mem_addr  output  32  word address to memory, {addr_q[31:2],2'b00}.
REQ-011 mem_wr  output  1  memory write enable, one cycle per store.
REQ-012 mem_wdata  output  32  merged write word.
REQ-013 mdr_out  output  32  memory data register; feeds the load-size stage.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 err  output  1  misaligned or invalid request flag.

Function
REQ-017 States SHALL be IDLE, RD, LATCH, WR, DONE; all outputs registered or decoded from state only.
REQ-018 In IDLE with start=1, we/op/addr/wdata SHALL be captured into addr_q/op_q/we_q/wdata_q; start while busy SHALL be ignored.
REQ-019 Error: op=11, or op=10 with addr[1:0]!=0, or op=01 with addr[0]!=0 -> IDLE->DONE directly, no mem_wr, mdr_out unchanged, err=1.
REQ-020 Load: IDLE->RD->LATCH->DONE->IDLE.
REQ-021 Store word: IDLE->WR->DONE->IDLE; no read issued.
REQ-022 Store byte/halfword (read-modify-write): IDLE->RD->LATCH->WR->DONE->IDLE.
REQ-023 RD SHALL last exactly MEM_LAT cycles, counted by a 3-bit down-counter loaded with MEM_LAT-1 on entry.
REQ-024 On the clock edge leaving LATCH, mdr_out SHALL load mem_rdata.
REQ-025 Merge: byte -> {mdr_out[31:8], wdata_q[7:0]}; halfword -> {mdr_out[31:16], wdata_q[15:0]}; word -> wdata_q.
REQ-026 mem_wr SHALL be 1 only in WR, with mem_wdata holding the merged word in that cycle; mem_wdata SHALL be 0 otherwise.
REQ-027 done SHALL be 1 only in DONE; err SHALL be valid in DONE and held until the next accepted start clears it.
REQ-028 Latency from start edge to done: load MEM_LAT+2 cycles; store word 2; store byte/half MEM_LAT+3; error 1.
REQ-029 mem_addr SHALL stay stable from accept through DONE.

Reset
REQ-030 reset_n=0 SHALL immediately force state IDLE, counter 0, mdr_out 0, mem_wr 0, done 0, err 0, busy 0, registered captures 0.
REQ-031 Reset asserted mid-operation SHALL abort with no mem_wr pulse after assertion; the first start after release SHALL behave as from power-up.

Structure
REQ-032 Package mem_access_pkg SHALL hold the op encodings (OP_BYTE, OP_HALF, OP_WORD) and the state enumeration.
REQ-033 The merge logic (REQ-025) SHALL be a combinational sub-module st_merge; everything else stays in mem_access.

Verification
REQ-034 Load word, MEM_LAT=1, addr=0x100, mem_rdata=0xDEADBEEF -> done on cycle 3 after start, mdr_out=0xDEADBEEF, mem_wr never 1.
REQ-035 Store byte, addr=0x104, wdata=0x000000AA, mem_rdata=0x11223344 -> single mem_wr with mem_wdata=0x112233AA, done 4 cycles after start.
REQ-036 Store halfword with MEM_LAT=3, mem_rdata=0xCAFEF00D, wdata=0x12345678 -> mem_wdata=0xCAFE5678, done 6 cycles after start.
REQ-037 Store word at addr=0x102 -> err=1 with done 1 cycle after start, no mem_wr, next valid start clears err.
REQ-038 reset_n dropped during RD of a store byte -> mem_wr stays 0, busy=0 immediately, mdr_out=0.
REQ-039 start held high through an entire load -> exactly one access and one done pulse; a second access begins only from IDLE.
